// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types: response codes, FSM state encodings and default window.
package axi4lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0600;
   localparam int unsigned DEF_DEPTH     = 256;

endpackage

// File: rtl/axi4lite_mem_array.sv
// Word-wide storage with a byte-enabled write port and a registered read port.
// Read returns the contents from before a same-edge write to the same word.
module axi4lite_mem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   wr_idx,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic [DATA_WIDTH/8-1:0]    wr_strb,
   input  logic                       rd_en,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [DATA_WIDTH-1:0]      rd_data
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
      if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite memory target: independent write and read FSMs, one outstanding
// transaction each, DECERR for accesses outside [BASE_ADDR, BASE_ADDR+size).
module axi4lite_slave_mem
   import axi4lite_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           DEPTH      = DEF_DEPTH,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEF_BASE_ADDR)
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [ADDR_WIDTH-1:0]     AWADDR,
   input  logic                      AWVALID,
   output logic                      AWREADY,
   input  logic [DATA_WIDTH-1:0]     WDATA,
   input  logic [DATA_WIDTH/8-1:0]   WSTRB,
   input  logic                      WVALID,
   output logic                      WREADY,
   output logic [1:0]                BRESP,
   output logic                      BVALID,
   input  logic                      BREADY,
   input  logic [ADDR_WIDTH-1:0]     ARADDR,
   input  logic                      ARVALID,
   output logic                      ARREADY,
   output logic [DATA_WIDTH-1:0]     RDATA,
   output logic [1:0]                RRESP,
   output logic                      RVALID,
   input  logic                      RREADY
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH * STRB_W);

   function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < WIN_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> OFF_W);
   endfunction

   // ---------------- write channel ----------------
   wr_state_t             wr_state;
   logic                  aw_done, w_done;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]     w_strb;

   logic                  aw_hs, w_hs, wr_go, wr_ok;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;

   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;
   // Commit on the edge where the later of AW/W arrives, using whichever
   // half is still on the bus and whichever was captured earlier.
   assign wr_addr = aw_done ? aw_addr : AWADDR;
   assign wr_data = w_done  ? w_data  : WDATA;
   assign wr_strb = w_done  ? w_strb  : WSTRB;
   assign wr_go   = ARESETN && (wr_state == W_IDLE) &&
                    (aw_done || aw_hs) && (w_done || w_hs);
   assign wr_ok   = in_win(wr_addr);

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_state <= W_IDLE;
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BRESP    <= OKAY;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (wr_go) begin
                  wr_state <= W_RESP;
                  AWREADY  <= 1'b0;
                  WREADY   <= 1'b0;
                  BVALID   <= 1'b1;
                  BRESP    <= wr_ok ? OKAY : DECERR;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
               end else begin
                  if (aw_hs) begin
                     aw_done <= 1'b1;
                     aw_addr <= AWADDR;
                  end
                  if (w_hs) begin
                     w_done <= 1'b1;
                     w_data <= WDATA;
                     w_strb <= WSTRB;
                  end
                  AWREADY <= !(aw_done || aw_hs);
                  WREADY  <= !(w_done || w_hs);
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  wr_state <= W_IDLE;
                  BVALID   <= 1'b0;
                  AWREADY  <= 1'b1;
                  WREADY   <= 1'b1;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // ---------------- read channel ----------------
   rd_state_t             rd_state;
   logic                  rd_ok;
   logic                  ar_hs, ar_ok;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign ar_hs = ARVALID && ARREADY;
   assign ar_ok = in_win(ARADDR);

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         rd_state <= R_IDLE;
         ARREADY  <= 1'b0;
         RVALID   <= 1'b0;
         RRESP    <= OKAY;
         rd_ok    <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rd_state <= R_DATA;
                  ARREADY  <= 1'b0;
                  RVALID   <= 1'b1;
                  RRESP    <= ar_ok ? OKAY : DECERR;
                  rd_ok    <= ar_ok;
               end else begin
                  ARREADY  <= 1'b1;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  rd_state <= R_IDLE;
                  RVALID   <= 1'b0;
                  ARREADY  <= 1'b1;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // The array's read register is not reset; rd_ok forces zero after reset
   // and for out-of-window reads.
   assign RDATA = rd_ok ? mem_rdata : '0;

   axi4lite_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (ACLK),
      .wr_en   (wr_go && wr_ok),
      .wr_idx  (word_idx(wr_addr)),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .rd_en   (ar_hs && ar_ok),
      .rd_idx  (word_idx(ARADDR)),
      .rd_data (mem_rdata)
   );

endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Self-checking bench for axi4lite_slave_mem with default parameters (window 0x600-0x9FF).
module tb_axi4lite_slave_mem;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [3:0]  WSTRB;
   logic [1:0]  BRESP, RRESP;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;

   always #5 ACLK = ~ACLK;

   axi4lite_slave_mem dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   localparam logic [1:0] OK = 2'b00;
   localparam logic [1:0] DE = 2'b11;

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [256];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          lead;   // >0: W leads AW by N cycles, <0: AW leads W
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;
   vec_t tbl [17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (a >= 32'h600) && (a < 32'hA00);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - 32'h600) >> 2);
   endfunction

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output logic [1:0] resp);
      int aw_at, w_at, t;
      bit aw_ok, w_ok;
      aw_at = (lead > 0) ? lead : 0;
      w_at  = (lead < 0) ? -lead : 0;
      aw_ok = 0; w_ok = 0; t = 0;
      AWADDR = a; WDATA = d; WSTRB = s;
      while (!(aw_ok && w_ok) && t < 40) begin
         AWVALID = !aw_ok && (t >= aw_at);
         WVALID  = !w_ok && (t >= w_at);
         @(negedge ACLK);
         if (t == 0) chk("w_idle_readys", {AWREADY, WREADY}, 2'b11);
         if (AWVALID && AWREADY) aw_ok = 1;
         if (WVALID && WREADY) w_ok = 1;
         step();
         t++;
      end
      AWVALID = 0; WVALID = 0;
      chk("aw_w_accept", {aw_ok, w_ok}, 2'b11);
      @(negedge ACLK);
      chk("b_latency", BVALID, 1'b1);
      t = 0;
      while (!BVALID && t < 20) begin
         @(negedge ACLK);
         t++;
      end
      resp = BRESP;
      step();
      if (in_win(a))
         for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[widx(a)][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
      int t;
      bit ok;
      ARADDR = a; ok = 0; t = 0;
      while (!ok && t < 40) begin
         ARVALID = 1;
         @(negedge ACLK);
         if (t == 0) chk("r_idle_ready", ARREADY, 1'b1);
         if (ARREADY) ok = 1;
         step();
         t++;
      end
      ARVALID = 0;
      chk("ar_accept", ok, 1'b1);
      @(negedge ACLK);
      chk("r_latency", RVALID, 1'b1);
      t = 0;
      while (!RVALID && t < 20) begin
         @(negedge ACLK);
         t++;
      end
      data = RDATA;
      resp = RRESP;
      step();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d, rd, old;
      logic [1:0]  rs, er;
      logic [3:0]  s;

      tbl[0]  = '{1'b1, 32'h600, 32'hDEADBEEF, 4'hF,     0, OK, 32'h0};
      tbl[1]  = '{1'b0, 32'h600, 32'h0,        4'h0,     0, OK, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 32'h604, 32'hAABBCCDD, 4'hF,     0, OK, 32'h0};
      tbl[3]  = '{1'b1, 32'h604, 32'h11223344, 4'b0101,  2, OK, 32'h0};
      tbl[4]  = '{1'b0, 32'h604, 32'h0,        4'h0,     0, OK, 32'hAA22CC44};
      tbl[5]  = '{1'b1, 32'h9FC, 32'h12345678, 4'hF,    -1, OK, 32'h0};
      tbl[6]  = '{1'b1, 32'hA00, 32'hFFFFFFFF, 4'hF,     0, DE, 32'h0};
      tbl[7]  = '{1'b0, 32'h9FC, 32'h0,        4'h0,     0, OK, 32'h12345678};
      tbl[8]  = '{1'b0, 32'h600, 32'h0,        4'h0,     0, OK, 32'hDEADBEEF};
      tbl[9]  = '{1'b0, 32'h5FC, 32'h0,        4'h0,     0, DE, 32'h0};
      tbl[10] = '{1'b1, 32'h604, 32'hFFFFFFFF, 4'h0,     0, OK, 32'h0};
      tbl[11] = '{1'b0, 32'h604, 32'h0,        4'h0,     0, OK, 32'hAA22CC44};
      tbl[12] = '{1'b1, 32'h60B, 32'hCAFEF00D, 4'hF,    -2, OK, 32'h0};
      tbl[13] = '{1'b0, 32'h608, 32'h0,        4'h0,     0, OK, 32'hCAFEF00D};
      tbl[14] = '{1'b0, 32'hA00, 32'h0,        4'h0,     0, DE, 32'h0};
      tbl[15] = '{1'b1, 32'h5FF, 32'h0,        4'hF,     1, DE, 32'h0};
      tbl[16] = '{1'b0, 32'h9FF, 32'h0,        4'h0,     0, OK, 32'h12345678};

      ARESETN = 0; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
      AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0;

      // reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         chk("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
         chk("rst_valids", {BVALID, RVALID}, 2'b00);
      end
      chk("rst_bresp", BRESP, 2'b00);
      chk("rst_rresp", RRESP, 2'b00);
      chk("rst_rdata", RDATA, 32'h0);
      step();
      ARESETN = 1;
      step();
      @(negedge ACLK);
      chk("rel_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
      step();

      // give every word a known value
      for (int i = 0; i < 256; i++) begin
         d = $urandom;
         do_write(32'h600 + 32'(i) * 4, d, 4'hF, 0, rs);
         chk("init_resp", rs, OK);
      end

      for (int i = 0; i < 17; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].lead, rs);
         end else begin
            do_read(tbl[i].addr, rd, rs);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
         end
         chk($sformatf("tbl%0d_resp", i), rs, tbl[i].resp);
      end

      // backpressure with same-edge write and read of 0x700
      old = ref_mem[widx(32'h700)];
      d = 32'h5A5AA5A5;
      BREADY = 0; RREADY = 0;
      AWADDR = 32'h700; WDATA = d; WSTRB = 4'hF; ARADDR = 32'h700;
      AWVALID = 1; WVALID = 1; ARVALID = 1;
      @(negedge ACLK);
      chk("cc_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
      step();
      AWVALID = 0; WVALID = 0; ARVALID = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         chk("bp_valids", {BVALID, RVALID}, 2'b11);
         chk("bp_rdata_old", RDATA, old);
         chk("bp_resps", {BRESP, RRESP}, 4'b0000);
         chk("bp_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
         step();
      end
      ref_mem[widx(32'h700)] = d;
      BREADY = 1; RREADY = 1;
      step();
      @(negedge ACLK);
      chk("bp_done_valids", {BVALID, RVALID}, 2'b00);
      chk("bp_done_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
      step();
      do_read(32'h700, rd, rs);
      chk("cc_new_rdata", rd, d);

      // randomized traffic against the reference array
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 8)       a = 32'h600 + $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
         else if (r == 8) a = $urandom_range(32'h400, 32'h5FF);
         else             a = $urandom_range(32'hA00, 32'hBFF);
         er = in_win(a) ? OK : DE;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, int'($urandom_range(0, 4)) - 2, rs);
            chk("rnd_bresp", rs, er);
         end else begin
            old = in_win(a) ? ref_mem[widx(a)] : 32'h0;
            do_read(a, rd, rs);
            chk("rnd_rresp", rs, er);
            chk("rnd_rdata", rd, old);
         end
      end

      // reset after AW accepted but before W
      old = ref_mem[widx(32'h608)];
      AWADDR = 32'h608;
      AWVALID = 1;
      @(negedge ACLK);
      chk("rmw_awready", AWREADY, 1'b1);
      step();
      AWVALID = 0;
      ARESETN = 0;
      WDATA = ~old; WSTRB = 4'hF; WVALID = 1;
      step();
      step();
      WVALID = 0;
      ARESETN = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         chk("rmw_no_bvalid", BVALID, 1'b0);
         step();
      end
      do_read(32'h608, rd, rs);
      chk("rmw_rdata", rd, old);
      chk("rmw_rresp", rs, OK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
